lpif_rxfifo_x16_asym2: RTL and testbench
========================================

# lpif_rxfifo_x16_asym2

Single-clock receive FIFO that buffers 281-bit LPIF x16 asym2 downstream words arriving from the link RX path. It presents them to the name-mapping slave stage on `rxfifo_downstream_data` with a valid/ready handshake. It also absorbs link-side bursts while the user side back-pressures, flushes when the link drops offline, and flags overflow.

## Interface
Parameters:
- `WIDTH`, 281: word width; must equal the LPIF x16 asym2 packed word width.
- `DEPTH`, 8: entry count; must be a power of two and at least 2.

Ports:
- `clk_wr`, input, 1: the block's single clock.
- `rst_wr_n`, input, 1: synchronous, active-low reset.
- `rx_online`, input, 1: link-aligned indication. Low means flush and ignore pushes.
- `link_push`, input, 1: `link_data_in` is valid this cycle.
- `link_data_in`, input, `WIDTH`: packed downstream word from the link RX path.
- `rxfifo_downstream_data`, output, `WIDTH`: head-of-FIFO word.
- `rxfifo_downstream_valid`, output, 1: the head word is valid.
- `user_downstream_ready`, input, 1: consumer accepts the head word this cycle.
- `fifo_full`, output, 1: count == `DEPTH`.
- `fifo_empty`, output, 1: count == 0.
- `fifo_count`, output, $clog2(`DEPTH`+1): number of occupied entries.
- `overflow_sticky`, output, 1: at least one word has been dropped since reset.

## Operation
- The FIFO is first-word-fall-through.
  - `rxfifo_downstream_valid` = !`fifo_empty`.
  - `rxfifo_downstream_data` = mem[rd_ptr], read combinationally.
  - `rxfifo_downstream_data` is don't-care while valid is low. The bench must not check it then.
- Pop happens when `rxfifo_downstream_valid` && `user_downstream_ready`. It advances rd_ptr by 1, modulo `DEPTH`.
- Push happens when `rx_online` && `link_push` && (!`fifo_full` || pop). It writes mem[wr_ptr] and advances wr_ptr by 1, modulo `DEPTH`.
- Count update per cycle:
  - push only: count + 1.
  - pop only: count − 1.
  - push and pop together: count unchanged.
- Pointers are log2(`DEPTH`) bits and wrap naturally. Full and empty are derived from the separate count register, never from pointer equality.
- Simultaneous push and pop when empty: the pop is impossible because valid is low. The push proceeds, and count goes to 1.
- Simultaneous push and pop when full: both proceed, and count stays at `DEPTH`. No drop occurs.
- Overflow: `rx_online` && `link_push` && `fifo_full` && !pop.
  - The word is discarded.
  - `overflow_sticky` is set to 1 on the next edge.
  - `overflow_sticky` is cleared only by reset. A flush does not clear it.
- Flush: on any cycle with `rx_online` = 0, the next edge sets rd_ptr, wr_ptr and count to 0.
  - `link_push` with `rx_online` low is ignored. It is not counted as overflow.
  - A pop attempted while `rx_online` is low has no effect beyond the flush.
- Reset (`rst_wr_n` low at an edge):
  - rd_ptr = 0, wr_ptr = 0, count = 0, `overflow_sticky` = 0.
  - `fifo_empty` = 1, `fifo_full` = 0, `rxfifo_downstream_valid` = 0.
  - Memory contents are not reset.
  - Reset mid-operation discards all stored words at that edge.

## Timing
- Push-to-valid latency is 1 cycle: a word pushed at edge N is visible on the output after edge N.
- Pop takes effect at the edge. The next head word is visible in the same cycle after that edge.
- Full throughput is one push and one pop per cycle indefinitely.
- `fifo_full`, `fifo_empty` and `fifo_count` are registered-state decodes. They change only at edges.
- `user_downstream_ready` may be asserted without valid. The consumer must not depend on ready to see valid.

## Structure
- `lpif_x16_asym2_pkg` holds:
  - the `LPIF_X16_ASYM2_WIDTH` = 281 constant;
  - field offset constants for state, protid, data, dvalid, crc, crc_valid and valid (bit positions 0, 4, 6, 262, 263, 279, 280);
  - a packed-word typedef.
- One sub-module, `lpif_rxfifo_mem`: a `DEPTH` × `WIDTH` register array with one synchronous write port and one asynchronous read port. Control, count and flags stay in the top module.

## Test plan
- Reset: hold `rst_wr_n` low 3 cycles while `link_push` = 1. Required after release: valid = 0, empty = 1, full = 0, count = 0, `overflow_sticky` = 0.
- Latency: with `rx_online` = 1, push 0x1A5 at edge N. Required: valid = 1 and data = 0x1A5 after edge N. Assert ready one cycle, then required: valid = 0 and count = 0.
- Fill and overflow: hold ready = 0 and push 1..9. Required:
  - count = 8 and full = 1;
  - word 9 is dropped and `overflow_sticky` = 1;
  - draining yields 1..8 in order.
- Full with simultaneous push and pop: at count 8, push 0xAA with ready = 1. Required: count stays 8, no overflow, 0xAA is read last.
- Wrap-around: stream 20 words with random ready (≈50%) and no drops. Required: output order identical to input, count never exceeds 8.
- Flush: with count = 5, drop `rx_online` for 1 cycle while pushing. Required: count = 0 and valid = 0 next cycle, `overflow_sticky` unchanged. After `rx_online` returns, the next push appears first.

Source files
------------

// File: rtl/lpif_x16_asym2_pkg.sv
// LPIF x16 asym2 downstream word layout shared by the RX path blocks.
// Field offsets are bit positions of each field's LSB within the 281-bit word.
package lpif_x16_asym2_pkg;

    localparam int LPIF_X16_ASYM2_WIDTH = 281;

    localparam int LPIF_STATE_OFS     = 0;
    localparam int LPIF_PROTID_OFS    = 4;
    localparam int LPIF_DATA_OFS      = 6;
    localparam int LPIF_DVALID_OFS    = 262;
    localparam int LPIF_CRC_OFS       = 263;
    localparam int LPIF_CRC_VALID_OFS = 279;
    localparam int LPIF_VALID_OFS     = 280;

    typedef struct packed {
        logic         valid;
        logic         crc_valid;
        logic [15:0]  crc;
        logic         dvalid;
        logic [255:0] data;
        logic [1:0]   protid;
        logic [3:0]   state;
    } lpif_x16_asym2_word_t;

endpackage

// File: rtl/lpif_rxfifo_mem.sv
// DEPTH x WIDTH register array: one synchronous write port, one asynchronous read port.
// Write lands at the edge; read data follows i_rd_addr combinationally; no backpressure.
module lpif_rxfifo_mem
    import lpif_x16_asym2_pkg::*;
#(
    parameter int WIDTH = LPIF_X16_ASYM2_WIDTH,
    parameter int DEPTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_wr_en,
    input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]         i_wr_data,
    input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
    output logic [WIDTH-1:0]         o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Storage is deliberately not reset; occupancy tracking lives in the controller.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/lpif_rxfifo_x16_asym2.sv
// First-word-fall-through RX FIFO for LPIF x16 asym2 words; push-to-valid 1 cycle.
// Link side cannot be stalled: a push into a full FIFO without a same-cycle pop is dropped and flagged sticky.
module lpif_rxfifo_x16_asym2
    import lpif_x16_asym2_pkg::*;
#(
    parameter int WIDTH = LPIF_X16_ASYM2_WIDTH,
    parameter int DEPTH = 8
) (
    input  logic                       clk_wr,
    input  logic                       rst_wr_n,
    input  logic                       rx_online,
    input  logic                       link_push,
    input  logic [WIDTH-1:0]           link_data_in,
    output logic [WIDTH-1:0]           rxfifo_downstream_data,
    output logic                       rxfifo_downstream_valid,
    input  logic                       user_downstream_ready,
    output logic                       fifo_full,
    output logic                       fifo_empty,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count,
    output logic                       overflow_sticky
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic          r_ovf;

    logic w_pop;
    logic w_push;
    logic w_drop;

    assign fifo_full               = (r_count == CW'(DEPTH));
    assign fifo_empty              = (r_count == '0);
    assign fifo_count              = r_count;
    assign overflow_sticky         = r_ovf;
    assign rxfifo_downstream_valid = !fifo_empty;

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push alongside it.
    assign w_pop  = rxfifo_downstream_valid && user_downstream_ready;
    assign w_push = rx_online && link_push && (!fifo_full || w_pop);
    assign w_drop = rx_online && link_push && fifo_full && !w_pop;

    lpif_rxfifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .i_clk     (clk_wr),
        .i_wr_en   (w_push),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (link_data_in),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (rxfifo_downstream_data)
    );

    always_ff @(posedge clk_wr) begin
        if (!rst_wr_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else if (!rx_online) begin
            // Link dropped: discard everything, but keep the drop history.
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CW'(1);
            end
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lpif_rxfifo_x16_asym2.sv
// Bench for the LPIF x16 asym2 RX FIFO: directed vector table, hand sequences, and a queue-based reference model.
module tb_lpif_rxfifo_x16_asym2;
    import lpif_x16_asym2_pkg::*;

    localparam int W = LPIF_X16_ASYM2_WIDTH;
    localparam int D = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         online;
    logic         push;
    logic         ready;
    logic [W-1:0] din;
    logic [W-1:0] dout;
    logic         vld;
    logic         full;
    logic         empty;
    logic [3:0]   cnt;
    logic         ovf;

    always #5 clk = ~clk;

    lpif_rxfifo_x16_asym2 #(.WIDTH(W), .DEPTH(D)) dut (
        .clk_wr                  (clk),
        .rst_wr_n                (rst_n),
        .rx_online               (online),
        .link_push               (push),
        .link_data_in            (din),
        .rxfifo_downstream_data  (dout),
        .rxfifo_downstream_valid (vld),
        .user_downstream_ready   (ready),
        .fifo_full               (full),
        .fifo_empty              (empty),
        .fifo_count              (cnt),
        .overflow_sticky         (ovf)
    );

    int n_vec = 0;
    int n_bad = 0;

    logic [W-1:0] mq[$];
    logic         m_ovf = 1'b0;

    typedef struct {
        logic         rst_n;
        logic         online;
        logic         push;
        logic         ready;
        logic [W-1:0] din;
        int           e_vld;
        int           e_cnt;
        int           e_full;
        int           e_ovf;
        logic [W-1:0] e_dat;
    } vec_t;

    vec_t tbl[$];

    task automatic chk_i(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic chk_w(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, advance the reference queue, then sample 1 time unit past the edge.
    task automatic step(input logic r, input logic o, input logic p,
                        input logic [W-1:0] d, input logic rd);
        rst_n  = r;
        online = o;
        push   = p;
        din    = d;
        ready  = rd;
        if (!r) begin
            mq.delete();
            m_ovf = 1'b0;
        end else if (!o) begin
            mq.delete();
        end else begin
            bit do_pop;
            bit was_full;
            do_pop   = (mq.size() > 0) && rd;
            was_full = (mq.size() == D);
            if (do_pop) void'(mq.pop_front());
            if (p) begin
                if (!was_full || do_pop) mq.push_back(d);
                else m_ovf = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        int sz;
        sz = mq.size();
        chk_i({tag, "_valid"}, int'(vld), int'(sz != 0));
        chk_i({tag, "_count"}, int'(cnt), sz);
        chk_i({tag, "_full"},  int'(full), int'(sz == D));
        chk_i({tag, "_empty"}, int'(empty), int'(sz == 0));
        chk_i({tag, "_ovf"},   int'(ovf), int'(m_ovf));
        if (sz != 0) chk_w({tag, "_data"}, dout, mq[0]);
    endtask

    function automatic vec_t mk(input logic r, input logic o, input logic p, input logic rd,
                                input logic [W-1:0] d, input int ev, input int ec,
                                input int ef, input int eo, input logic [W-1:0] ed);
        vec_t v;
        v.rst_n = r; v.online = o; v.push = p; v.ready = rd; v.din = d;
        v.e_vld = ev; v.e_cnt = ec; v.e_full = ef; v.e_ovf = eo; v.e_dat = ed;
        return v;
    endfunction

    initial begin
        logic [W-1:0] sent[$];
        logic [W-1:0] got[$];
        logic [W-1:0] w;
        int           npush;
        int           cyc;

        // Reset held 3 cycles with pushes asserted, then release.
        for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 1, 1, 0, W'(i + 100), 0, 0, 0, 0, '0));
        tbl.push_back(mk(1, 1, 0, 0, '0, 0, 0, 0, 0, '0));
        // Single word latency and pop.
        tbl.push_back(mk(1, 1, 1, 0, W'(32'h1A5), 1, 1, 0, 0, W'(32'h1A5)));
        tbl.push_back(mk(1, 1, 0, 1, '0, 0, 0, 0, 0, '0));
        // Fill with 1..8, then word 9 is dropped.
        for (int i = 1; i <= 8; i++) tbl.push_back(mk(1, 1, 1, 0, W'(i), 1, i, int'(i == 8), 0, W'(1)));
        tbl.push_back(mk(1, 1, 1, 0, W'(9), 1, 8, 1, 1, W'(1)));
        // Drain: head after k pops is k+1.
        for (int k = 1; k <= 8; k++) tbl.push_back(mk(1, 1, 0, 1, '0, int'(k < 8), 8 - k, 0, 1, W'(k + 1)));

        foreach (tbl[i]) begin
            step(tbl[i].rst_n, tbl[i].online, tbl[i].push, tbl[i].din, tbl[i].ready);
            chk_i($sformatf("tbl%0d_valid", i), int'(vld),   tbl[i].e_vld);
            chk_i($sformatf("tbl%0d_empty", i), int'(empty), int'(tbl[i].e_vld == 0));
            chk_i($sformatf("tbl%0d_count", i), int'(cnt),   tbl[i].e_cnt);
            chk_i($sformatf("tbl%0d_full", i),  int'(full),  tbl[i].e_full);
            chk_i($sformatf("tbl%0d_ovf", i),   int'(ovf),   tbl[i].e_ovf);
            if (tbl[i].e_vld != 0) chk_w($sformatf("tbl%0d_data", i), dout, tbl[i].e_dat);
        end

        // Full with simultaneous push and pop: no drop, 0xAA lands last.
        step(0, 1, 0, '0, 0);
        for (int i = 1; i <= 8; i++) step(1, 1, 1, W'(i), 0);
        check_model("fill8");
        step(1, 1, 1, W'(32'hAA), 1);
        chk_i("fullpp_count", int'(cnt), 8);
        chk_i("fullpp_ovf", int'(ovf), 0);
        for (int k = 2; k <= 9; k++) begin
            chk_w($sformatf("fullpp_head%0d", k), dout, (k == 9) ? W'(32'hAA) : W'(k));
            step(1, 1, 0, '0, 1);
        end
        check_model("fullpp_end");

        // Random-ready streaming of 20 wide random words without drops.
        npush = 0;
        cyc   = 0;
        while ((npush < 20 || mq.size() != 0) && cyc < 400) begin
            logic rd;
            logic p;
            rd = 1'($urandom_range(0, 1));
            p  = (npush < 20) && ($urandom_range(0, 3) != 0) && (mq.size() < D || (rd && mq.size() > 0));
            w  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            if (p) begin
                sent.push_back(w);
                npush++;
            end
            if (vld && rd) got.push_back(dout);
            step(1, 1, p, w, rd);
            check_model("rand");
            chk_i("rand_count_le8", int'(cnt <= 4'd8), 1);
            cyc++;
        end
        chk_i("rand_done_in_budget", int'(cyc < 400), 1);
        chk_i("rand_nrecv", got.size(), 20);
        for (int i = 0; i < 20 && i < got.size(); i++) chk_w($sformatf("rand_order%0d", i), got[i], sent[i]);

        // Flush at count 5 with overflow already sticky; pop while offline must not matter.
        for (int i = 1; i <= 9; i++) step(1, 1, 1, W'(i + 40), 0);
        for (int i = 0; i < 3; i++) step(1, 1, 0, '0, 1);
        check_model("preflush");
        chk_i("preflush_count", int'(cnt), 5);
        step(1, 0, 1, W'(32'h55), 1);
        chk_i("flush_count", int'(cnt), 0);
        chk_i("flush_valid", int'(vld), 0);
        chk_i("flush_ovf", int'(ovf), 1);
        step(1, 1, 1, W'(32'h77), 0);
        chk_i("postflush_count", int'(cnt), 1);
        chk_w("postflush_head", dout, W'(32'h77));
        check_model("postflush");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
